step_envelope: RTL

//  Downstream consumer of the serial bitrotate pattern: turns the rotating
//  one-bit step stream into an attack/decay amplitude envelope. A trigger

---
 rtl/env_pkg.sv | 21 ++
 rtl/tick_divider.sv | 35 +++
 rtl/step_envelope.sv | 105 ++++++++++
 3 files changed

// File: rtl/env_pkg.sv
`default_nettype none
// =============================================================================
// env_pkg
// Shared state encoding and level helpers for the step envelope generator.
// Revision: 1.0
// =============================================================================
package env_pkg;

    typedef enum logic [1:0] {
        ENV_IDLE   = 2'd0,
        ENV_ATTACK = 2'd1,
        ENV_DECAY  = 2'd2
    } env_state_t;

    // Full-scale level for a given level width (valid for widths up to 31).
    function automatic int unsigned level_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// =============================================================================
// tick_divider
// Free-running prescaler emitting a one-cycle tick every PRESCALE clocks.
// Revision: 1.0
// =============================================================================
module tick_divider #(
    parameter int PRESCALE = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] c_last = CW'(PRESCALE - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (restart || (r_count == c_last)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    // A restart cycle never ticks, so the first tick lands PRESCALE clocks later.
    assign tick = (r_count == c_last) && !restart;

endmodule
`default_nettype wire

// File: rtl/step_envelope.sv
`default_nettype none
// =============================================================================
// step_envelope
// Attack/decay envelope triggered by the rotating step pattern.
// Revision: 1.0
// =============================================================================
module step_envelope
    import env_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 64,
    parameter int RETRIG   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             gate_in,
    input  logic [WIDTH-1:0] attack_inc,
    input  logic [WIDTH-1:0] decay_dec,
    output logic [WIDTH-1:0] level,
    output logic             busy,
    output logic             trig_out
);

    localparam logic [WIDTH:0] c_level_max = (WIDTH+1)'(level_max(WIDTH));
    localparam logic           c_retrig    = (RETRIG != 0);

    env_state_t       r_state;
    env_state_t       w_state_next;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] w_level_next;
    logic             r_prev_gate;
    logic             r_trig_out;
    logic             w_trig;
    logic             w_tick;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_dec;

    assign w_trig = step & gate_in & (c_retrig | ~r_prev_gate);

    tick_divider #(
        .PRESCALE (PRESCALE)
    ) u_tick_divider (
        .clk     (clk),
        .rst     (rst),
        .restart (w_trig),
        .tick    (w_tick)
    );

    // Trigger wins over a coincident tick; a retrigger keeps the current level.
    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        w_sum        = {1'b0, r_level} + {1'b0, attack_inc};
        w_dec        = (decay_dec == '0) ? WIDTH'(1) : decay_dec;
        if (w_trig) begin
            w_state_next = ENV_ATTACK;
        end else if (w_tick) begin
            case (r_state)
                ENV_ATTACK: begin
                    if ((attack_inc == '0) || (w_sum >= c_level_max)) begin
                        w_level_next = c_level_max[WIDTH-1:0];
                        w_state_next = ENV_DECAY;
                    end else begin
                        w_level_next = w_sum[WIDTH-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (r_level <= w_dec) begin
                        w_level_next = '0;
                        w_state_next = ENV_IDLE;
                    end else begin
                        w_level_next = r_level - w_dec;
                    end
                end
                default: begin
                    w_level_next = '0;
                    w_state_next = ENV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ENV_IDLE;
            r_level     <= '0;
            r_prev_gate <= 1'b0;
            r_trig_out  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_level    <= w_level_next;
            r_trig_out <= w_trig;
            if (step) begin
                r_prev_gate <= gate_in;
            end
        end
    end

    assign level    = r_level;
    assign busy     = (r_state != ENV_IDLE);
    assign trig_out = r_trig_out;

endmodule
`default_nettype wire
